pipe_hazard_ctrl: RTL and testbench

Parametrised hazard and forwarding controller for the in-order MIPS pipeline. It generalises the separate lw-hazard, branch-hazard and forwarding logic into one block with a configurable number of post-ID stages and configurable result-ready stages. A shift-register scoreboard follows every instruction issued from ID. From it the block produces the stall, the IF/ID flush, the ID/EX bubble and the per-operand bypass selects for the instruction currently in ID.

---
 rtl/pipe_hazard_ctrl.sv | 100 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: scoreboard-based stall, flush, bubble and bypass control for the ID stage
// Ports: clock_i/reset_i (async active-high); id_* describe the instruction in ID;
//   redirect_i = taken branch/jump in ID; stall_ext_i = external freeze;
//   stall_o/flush_ifid_o/bubble_idex_o pipeline control; fwd_rs_o/fwd_rt_o bypass selects
//   (0 = register file, k = scoreboard entry k-1); sb_busy_o = any entry valid.
// Optional macro HAZARD_PERF_EN adds saturating stall_cnt_o/flush_cnt_o counters.
module pipe_hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int READY_ALU  = 0,
  parameter int READY_LOAD = 1,
  parameter int SEL_W      = 2
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic [REG_AW-1:0] id_dst_i,
  input  logic              id_wr_i,
  input  logic              id_load_i,
  input  logic              redirect_i,
  input  logic              stall_ext_i,
  output logic              stall_o,
  output logic              flush_ifid_o,
  output logic              bubble_idex_o,
  output logic [SEL_W-1:0]  fwd_rs_o,
  output logic [SEL_W-1:0]  fwd_rt_o,
  output logic              sb_busy_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]       stall_cnt_o,
  output logic [15:0]       flush_cnt_o
`endif
);
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] dst;
    logic              wr;
    logic              ld;
  } ent_t;
  ent_t [DEPTH-1:0] sb_q, sb_d;
  ent_t             new_ent;
  logic             haz_rs, haz_rt, busy;
  logic [SEL_W-1:0] sel_rs, sel_rt;
  function automatic logic hit(ent_t e, logic [REG_AW-1:0] r, logic use_r);
    return e.v && e.wr && e.dst == r && r != '0 && use_r && id_valid_i;
  endfunction
  // Walk oldest to youngest so the youngest (lowest index) match overrides.
  always_comb begin
    haz_rs = 1'b0;
    haz_rt = 1'b0;
    sel_rs = '0;
    sel_rt = '0;
    busy   = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      busy = busy | sb_q[k].v;
      if (hit(sb_q[k], id_rs_i, id_use_rs_i)) begin
        sel_rs = SEL_W'(k + 1);
        haz_rs = k < (sb_q[k].ld ? READY_LOAD : READY_ALU);
      end
      if (hit(sb_q[k], id_rt_i, id_use_rt_i)) begin
        sel_rt = SEL_W'(k + 1);
        haz_rt = k < (sb_q[k].ld ? READY_LOAD : READY_ALU);
      end
    end
  end
  assign stall_o       = haz_rs | haz_rt | stall_ext_i;
  assign bubble_idex_o = stall_o & ~stall_ext_i;
  assign flush_ifid_o  = redirect_i & ~stall_o;
  assign fwd_rs_o      = stall_o ? '0 : sel_rs;
  assign fwd_rt_o      = stall_o ? '0 : sel_rt;
  assign sb_busy_o     = busy;
  // A hazard stall still advances older instructions but issues a bubble into EX.
  assign new_ent = stall_o ? '0 : {id_valid_i, id_dst_i, id_wr_i, id_load_i};
  assign sb_d    = stall_ext_i ? sb_q : {sb_q[DEPTH-2:0], new_ent};
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) sb_q <= '0;
    else         sb_q <= sb_d;
  end
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  assign stall_cnt_d = stall_cnt_q + 16'(stall_o && stall_cnt_q != 16'hFFFF);
  assign flush_cnt_d = flush_cnt_q + 16'(flush_ifid_o && flush_cnt_q != 16'hFFFF);
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of stall, flush, bubble and bypass selection
module tb_pipe_hazard_ctrl;
  logic       clk = 1'b0, rst = 1'b1;
  logic       id_valid, id_use_rs, id_use_rt, id_wr, id_load, redirect, stall_ext;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       stall, flush_ifid, bubble_idex, sb_busy;
  logic [1:0] fwd_rs, fwd_rt;
  int         total = 0, bad = 0;
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif
  pipe_hazard_ctrl dut (
    .clock_i(clk), .reset_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt), .id_dst_i(id_dst), .id_wr_i(id_wr),
    .id_load_i(id_load), .redirect_i(redirect), .stall_ext_i(stall_ext), .stall_o(stall),
    .flush_ifid_o(flush_ifid), .bubble_idex_o(bubble_idex), .fwd_rs_o(fwd_rs),
    .fwd_rt_o(fwd_rt), .sb_busy_o(sb_busy)
`ifdef HAZARD_PERF_EN
    , .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt, input logic [4:0] dst,
                     input logic wr, input logic ld);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_dst = dst; id_wr = wr; id_load = ld;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    set(0, 0, 0, 0, 0, 0, 0, 0);
    stall_ext = 0;
    redirect  = 1;
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_flush", flush_ifid, 1);
    chk("rst_busy", sb_busy, 0);
    chk("rst_bubble", bubble_idex, 0);
    chk("rst_fwd", {fwd_rs, fwd_rt}, 0);
    redirect = 0;
    @(negedge clk) rst = 0;
    tick();
    set(1, 0, 0, 0, 0, 8, 1, 1);
    #1 chk("lw_issue_stall", stall, 0);
    tick();
    set(1, 8, 10, 1, 1, 9, 1, 0);
    redirect = 1;
    #1 chk("lu_stall", stall, 1);
    chk("lu_bubble", bubble_idex, 1);
    chk("lu_fwd_rs", fwd_rs, 0);
    chk("lu_flush_blocked", flush_ifid, 0);
    tick();
    redirect = 0;
    #1 chk("lu_after_stall", stall, 0);
    chk("lu_after_fwd_rs", fwd_rs, 2);
    chk("lu_after_fwd_rt", fwd_rt, 0);
    tick();
    set(1, 1, 2, 1, 1, 8, 1, 0);
    redirect = 1;
    #1 chk("redir_flush", flush_ifid, 1);
    chk("redir_fwd_rs", fwd_rs, 0);
    redirect = 0;
    tick();
    set(1, 8, 8, 1, 1, 9, 1, 0);
    #1 chk("alu_stall", stall, 0);
    chk("alu_fwd_rs", fwd_rs, 1);
    chk("alu_fwd_rt", fwd_rt, 1);
    tick();
    set(1, 0, 0, 0, 0, 8, 1, 0);
    tick();
    tick();
    set(1, 8, 0, 1, 1, 3, 1, 0);
    #1 chk("young_fwd_rs", fwd_rs, 1);
    chk("young_fwd_rt", fwd_rt, 0);
    tick();
    set(1, 8, 3, 1, 1, 0, 0, 0);
    #1 chk("older_fwd_rs", fwd_rs, 2);
    chk("older_fwd_rt", fwd_rt, 1);
    tick();
    set(1, 0, 0, 0, 0, 0, 1, 1);
    tick();
    set(1, 0, 0, 1, 1, 0, 0, 0);
    #1 chk("r0_stall", stall, 0);
    chk("r0_fwd", {fwd_rs, fwd_rt}, 0);
    chk("r0_busy", sb_busy, 1);
    tick();
    set(1, 0, 0, 0, 0, 5, 1, 1);
    tick();
    set(1, 5, 0, 1, 0, 6, 1, 0);
    stall_ext = 1;
    redirect  = 1;
    #1 chk("ext_stall", stall, 1);
    chk("ext_bubble", bubble_idex, 0);
    chk("ext_flush", flush_ifid, 0);
    redirect = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ext_hold_bubble", bubble_idex, 0);
    end
    stall_ext = 0;
    #1 chk("ext_rel_stall", stall, 1);
    chk("ext_rel_bubble", bubble_idex, 1);
    tick();
    chk("ext_after_stall", stall, 0);
    chk("ext_after_fwd_rs", fwd_rs, 2);
    tick();
    set(1, 0, 0, 0, 0, 7, 1, 1);
    tick();
    set(1, 7, 0, 1, 0, 1, 1, 0);
    #1 chk("pre_rst_stall", stall, 1);
    chk("pre_rst_busy", sb_busy, 1);
    rst = 1;
    #1 chk("mid_rst_stall", stall, 0);
    chk("mid_rst_busy", sb_busy, 0);
    stall_ext = 1;
    #1 chk("mid_rst_ext_stall", stall, 1);
    chk("mid_rst_ext_bubble", bubble_idex, 0);
    @(negedge clk);
    rst = 0;
    stall_ext = 0;
    set(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("drain_busy", sb_busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
